// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one dual-port SRAM bank (port 0 write-only, port 1 read-only, active-low
// selects) between two write requesters and two read requesters. Each port uses
// its own round-robin arbiter with valid/ready handshakes. All SRAM control lines
// are registered. A read whose address matches the write granted in the same
// cycle is held off. Read data returns two cycles after the handshake, tagged
// one-hot with the requester index.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_valid/wr_ready       per-requester write handshake (bit i = requester i)
//   wr_addr_*/wr_data_*     write address/data per requester
//   rd_valid/rd_ready       per-requester read handshake
//   rd_addr_*               read address per requester
//   rd_resp_valid           one-hot, one-cycle response strobe
//   rd_resp_data            read response data
//   csb0/web0/addr0/din0    SRAM port 0 (write)
//   csb1/addr1/dout1        SRAM port 1 (read)
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            wr_valid,
  output logic [1:0]            wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr_0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_1,
  input  logic [DATA_WIDTH-1:0] wr_data_0,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic [1:0]            rd_valid,
  output logic [1:0]            rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr_0,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [1:0]            rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            wr_gnt;
  logic [1:0]            rd_cand;
  logic [1:0]            rd_gnt;
  logic [ADDR_WIDTH-1:0] wr_gnt_addr;
  logic [DATA_WIDTH-1:0] wr_gnt_data;
  logic [ADDR_WIDTH-1:0] rd_cand_addr;
  logic                  collide;

  // Read id pipeline: stage 1 aligns with the SRAM command, stage 2 with dout1.
  logic rd_p1_vld_q, rd_p1_id_q;
  logic rd_p2_vld_q, rd_p2_id_q;

  always_comb begin
    wr_gnt = 2'b00;
    case (wr_valid)
      2'b01:   wr_gnt = 2'b01;
      2'b10:   wr_gnt = 2'b10;
      2'b11:   wr_gnt = wr_ptr_q ? 2'b10 : 2'b01;
      default: wr_gnt = 2'b00;
    endcase

    rd_cand = 2'b00;
    case (rd_valid)
      2'b01:   rd_cand = 2'b01;
      2'b10:   rd_cand = 2'b10;
      2'b11:   rd_cand = rd_ptr_q ? 2'b10 : 2'b01;
      default: rd_cand = 2'b00;
    endcase

    wr_gnt_addr  = wr_gnt[1] ? wr_addr_1 : wr_addr_0;
    wr_gnt_data  = wr_gnt[1] ? wr_data_1 : wr_data_0;
    rd_cand_addr = rd_cand[1] ? rd_addr_1 : rd_addr_0;

    // A same-address read waits a cycle so it observes the new data; the other
    // reader is deliberately not promoted in its place.
    collide = (|wr_gnt) && (|rd_cand) && (rd_cand_addr == wr_gnt_addr);
    rd_gnt  = collide ? 2'b00 : rd_cand;
  end

  assign wr_ready = rst_n ? wr_gnt : 2'b00;
  assign rd_ready = rst_n ? rd_gnt : 2'b00;

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (|wr_gnt) wr_ptr_q <= wr_gnt[0];
      if (|rd_gnt) rd_ptr_q <= rd_gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else begin
      csb0 <= ~(|wr_gnt);
      web0 <= ~(|wr_gnt);
      if (|wr_gnt) begin
        addr0 <= wr_gnt_addr;
        din0  <= wr_gnt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb1 <= 1'b1;
      addr1 <= '0;
    end else begin
      csb1 <= ~(|rd_gnt);
      if (|rd_gnt) addr1 <= rd_cand_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_vld_q   <= 1'b0;
      rd_p1_id_q    <= 1'b0;
      rd_p2_vld_q   <= 1'b0;
      rd_p2_id_q    <= 1'b0;
      rd_resp_valid <= 2'b00;
      rd_resp_data  <= '0;
    end else begin
      rd_p1_vld_q <= |rd_gnt;
      rd_p1_id_q  <= rd_gnt[1];
      rd_p2_vld_q <= rd_p1_vld_q;
      rd_p2_id_q  <= rd_p1_id_q;
      if (rd_p2_vld_q) begin
        rd_resp_valid <= rd_p2_id_q ? 2'b10 : 2'b01;
        rd_resp_data  <= dout1;
      end else begin
        rd_resp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the dual-port SRAM macro (port 0 write-only, port 1 read-only, active-low chip selects). It shares the write port between two write requesters and the read port between two read requesters using independent round-robin arbitration with valid/ready handshakes. It registers all SRAM control lines, blocks same-address read/write collisions, and returns read data tagged with the requester index. It sits between the accelerator's loaders/writeback units and one SRAM bank.

## Interface
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 12, SRAM address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  2  write request valid, bit i = requester i
- wr_ready  out  2  write request accepted when valid&ready at clk edge
- wr_addr_0 / wr_addr_1  in  ADDR_WIDTH  write address per requester
- wr_data_0 / wr_data_1  in  DATA_WIDTH  write data per requester
- rd_valid  in  2  read request valid
- rd_ready  out  2  read request accepted when valid&ready
- rd_addr_0 / rd_addr_1  in  ADDR_WIDTH  read address per requester
- rd_resp_valid  out  2  one-hot, one-cycle pulse marking which requester owns rd_resp_data
- rd_resp_data  out  DATA_WIDTH  read data
- csb0, web0  out  1  SRAM port-0 chip select / write enable (active low)
- addr0  out  ADDR_WIDTH ; din0  out  DATA_WIDTH  SRAM port-0 address/data
- csb1  out  1 ; addr1  out  ADDR_WIDTH  SRAM port-1 select/address
- dout1  in  DATA_WIDTH  SRAM port-1 read data

## Operation
- Write arbiter: if exactly one wr_valid bit set, that requester is granted. If both are set, the requester selected by wr_ptr is granted. wr_ready = grant, combinational from wr_valid and wr_ptr. Ready never asserts without valid.
- On an accepted write, wr_ptr moves to the other requester. With no accept, wr_ptr holds.
- Read arbiter: identical structure with rd_ptr, subject to the collision rule below.
- Collision rule: if a write is granted this cycle and the read candidate's address equals the granted write address, rd_ready for that requester is 0. The other reader is not granted in its place. rd_ptr holds, and the read retries next cycle, returning the newly written data.
- Accepted write: at the next edge, csb0=0, web0=0, addr0/din0 take the request. With no accept, csb0=1 and web0=1; addr0/din0 hold.
- Accepted read: at the next edge, csb1=0, addr1 takes the request. With no accept, csb1=1; addr1 holds.
- The requester index of each read travels through a 2-stage valid/id pipeline. When it exits, dout1 is captured into rd_resp_data and the matching rd_resp_valid bit pulses for one cycle.
- Responses have no backpressure; requesters must accept them.
- Reset (async, any time): csb0=1, web0=1, csb1=1, addr0=0, din0=0, addr1=0, wr_ptr=0, rd_ptr=0, rd_resp_valid=0, rd_resp_data=0, id pipeline cleared. In-flight reads are dropped and produce no response. wr_ready/rd_ready are 0 while rst_n=0.

## Timing
- Throughput: one write and one read per cycle, sustained.
- Write: handshake at edge E0 → SRAM pins driven after E0 → SRAM commits at E1.
- Read: handshake at E0 → csb1/addr1 driven after E0 → SRAM samples at E1, dout1 valid during E1..E2 → captured at E2. rd_resp_valid/rd_resp_data are high/valid for the cycle after E2. Latency is 2 cycles, in-order.
- Back-to-back reads return back-to-back responses in acceptance order.
- Write accepted at E0 and read of the same address accepted at E1: the read returns the new data.
- Simultaneous same-address write/read at the same edge never occurs, per the collision rule.

## Test plan
- Reset: hold rst_n=0 mid-stream with both valids high → all outputs at reset values, ready=0. Release → requester 0 is granted first on both ports.
- Single write then read: write 0x000 ← 0xAAAAAAAA via requester 0, then read 0x000 via requester 1 → rd_resp_valid=2'b10, rd_resp_data=0xAAAAAAAA, 2 cycles after the read handshake.
- Contention: both writers valid for 4 cycles (addresses 0x010/0x020, data 0x11111111/0x22222222) → grants alternate 0,1,0,1; csb0 low for 4 consecutive cycles. Readback matches.
- Collision: writer 0 writes 0x055 ← 0x12345678 while reader 0 reads 0x055 in the same cycle → rd_ready=0 that cycle, accepted next cycle, returns 0x12345678.
- Streaming reads: 8 alternating reads from both readers over addresses 0x100–0x107, preloaded with value=address → 8 consecutive responses in order, with correct one-hot ids.
- Reset mid-read: assert rst_n=0 one cycle after a read handshake → no rd_resp_valid pulse after reset release.
